// File: rtl/btb_set_assoc.sv
// -----------------------------------------------------------------------------
// btb_set_assoc
// Set-associative branch target buffer with 2-bit saturating direction
// counters, true-LRU replacement and a one-set-per-cycle flush walk.
//
// Optional feature: define BTB_STATS_EN to add the hit_cnt / miss_cnt
// statistics counters and their ports.
//
// Parameters
//   SETS  number of sets (power of two, 4..256)
//   WAYS  ways per set (1, 2 or 4)
//
// Ports
//   CLK            clock, rising edge
//   nRST           asynchronous active-low reset
//   lookup_valid   fetch-stage query strobe
//   lookup_pc      fetch-stage query address
//   lookup_hit     query hit (same cycle, combinational)
//   lookup_taken   predicted direction of the hitting entry
//   lookup_target  predicted target of the hitting entry (0 on miss)
//   upd_en         resolved-branch update strobe from execute
//   upd_pc         resolved branch address
//   upd_target     resolved branch target
//   upd_taken      resolved branch direction
//   flush          request to invalidate every entry
//   busy           flush walk in progress
//   hit_cnt        saturating count of hitting lookups   (BTB_STATS_EN)
//   miss_cnt       saturating count of missing lookups   (BTB_STATS_EN)
// -----------------------------------------------------------------------------
module btb_set_assoc #(
   parameter int SETS = 64,
   parameter int WAYS = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        lookup_hit,
   output logic        lookup_taken,
   output logic [31:0] lookup_target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        flush,
   output logic        busy
`ifdef BTB_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int IDXW = $clog2(SETS);
   localparam int TAGW = 30 - IDXW;
   // WAYS=1 keeps a 1-bit way/age field that simply stays 0.
   localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int AGEW = WAYW;
   localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(WAYS - 1);
   localparam logic [IDXW-1:0] LAST_SET = IDXW'(SETS - 1);

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   // Entry storage
   logic            valid_q  [SETS][WAYS];
   logic [TAGW-1:0] tag_q    [SETS][WAYS];
   logic [31:0]     target_q [SETS][WAYS];
   logic [1:0]      ctr_q    [SETS][WAYS];
   logic [AGEW-1:0] age_q    [SETS][WAYS];

   // Address bits [1:0] carry no information for word-aligned branches.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Flush FSM
   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic            clear_en;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clear_en = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush) begin
               state_d = FLUSH;
               ptr_d   = '0;
            end
         end
         FLUSH: begin
            busy     = 1'b1;
            clear_en = 1'b1;
            if (flush) begin
               // A new request restarts the walk from set 0.
               ptr_d = '0;
            end else begin
               ptr_d = ptr_q + IDXW'(1);
               if (ptr_q == LAST_SET) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lookup path (reads pre-update contents)
   logic [IDXW-1:0] lk_idx;
   logic [TAGW-1:0] lk_tag;
   logic            lk_match;
   logic            lk_dir;
   logic [31:0]     lk_tgt;

   assign lk_idx = lookup_pc[2+IDXW-1:2];
   assign lk_tag = lookup_pc[31:2+IDXW];

   always_comb begin
      lk_match = 1'b0;
      lk_dir   = 1'b0;
      lk_tgt   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!lk_match && valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
            lk_match = 1'b1;
            lk_dir   = ctr_q[lk_idx][w][1];
            lk_tgt   = target_q[lk_idx][w];
         end
      end
   end

   assign lookup_hit    = lookup_valid && lk_match && !busy;
   assign lookup_taken  = lookup_hit && lk_dir;
   assign lookup_target = lookup_hit ? lk_tgt : 32'h0;

   // Update path: hit detection and victim choice
   logic [IDXW-1:0] up_idx;
   logic [TAGW-1:0] up_tag;
   logic            up_hit;
   logic [WAYW-1:0] up_hit_way;
   logic            has_inv;
   logic [WAYW-1:0] inv_way;
   logic [WAYW-1:0] lru_way;
   logic [AGEW-1:0] lru_age;
   logic [WAYW-1:0] touch_way;
   logic [AGEW-1:0] old_age;
   logic            upd_write;

   assign up_idx = upd_pc[2+IDXW-1:2];
   assign up_tag = upd_pc[31:2+IDXW];

   always_comb begin
      up_hit     = 1'b0;
      up_hit_way = '0;
      has_inv    = 1'b0;
      inv_way    = '0;
      lru_way    = '0;
      lru_age    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!up_hit && valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
            up_hit     = 1'b1;
            up_hit_way = WAYW'(w);
         end
         if (!has_inv && !valid_q[up_idx][w]) begin
            has_inv = 1'b1;
            inv_way = WAYW'(w);
         end
         // Oldest way, ties resolved toward the lowest index.
         if (w == 0 || age_q[up_idx][w] > lru_age) begin
            lru_way = WAYW'(w);
            lru_age = age_q[up_idx][w];
         end
      end
   end

   // On allocation the incoming way is treated as the oldest, so every valid
   // way ages by one; ages of invalid ways saturate and are never consulted.
   always_comb begin
      touch_way = up_hit ? up_hit_way : (has_inv ? inv_way : lru_way);
      old_age   = up_hit ? age_q[up_idx][up_hit_way] : AGE_MAX;
   end

   // Updates are dropped while walking and on the cycle that starts a walk.
   assign upd_write = upd_en && (state_q == IDLE) && !flush && (up_hit || upd_taken);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               ctr_q[s][w]    <= '0;
               age_q[s][w]    <= '0;
            end
         end
      end else begin
         if (clear_en) begin
            for (int w = 0; w < WAYS; w++) valid_q[ptr_q][w] <= 1'b0;
         end
         if (upd_write) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAYW'(w) == touch_way) begin
                  valid_q[up_idx][w]  <= 1'b1;
                  tag_q[up_idx][w]    <= up_tag;
                  target_q[up_idx][w] <= upd_target;
                  age_q[up_idx][w]    <= '0;
                  if (up_hit)
                     ctr_q[up_idx][w] <= upd_taken ? ctr_inc(ctr_q[up_idx][w])
                                                   : ctr_dec(ctr_q[up_idx][w]);
                  else
                     ctr_q[up_idx][w] <= 2'b10;
               end else if (age_q[up_idx][w] < old_age) begin
                  age_q[up_idx][w] <= age_q[up_idx][w] + AGEW'(1);
               end
            end
         end
      end
   end

`ifdef BTB_STATS_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Lookups during a flush walk always miss and are counted as misses.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (lookup_valid) begin
         if (lookup_hit) hit_cnt  <= sat_inc32(hit_cnt);
         else            miss_cnt <= sat_inc32(miss_cnt);
      end
   end
`endif

endmodule

// File: doc/btb_set_assoc.md
BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

Interface
REQ-001 SHALL provide parameter SETS, default 64, number of sets; power of two, 4..256.
REQ-002 SHALL provide parameter WAYS, default 2, ways per set; one of 1, 2, 4.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports lookup_valid input 1 and lookup_pc input 32: fetch-stage query.
REQ-006 SHALL have outputs lookup_hit 1, lookup_taken 1 and lookup_target 32: prediction result.
REQ-007 SHALL have inputs upd_en 1, upd_pc 32, upd_target 32 and upd_taken 1: resolved branch from execute.
REQ-008 SHALL have input flush 1 (invalidate all) and output busy 1 (flush walk in progress).
REQ-009 SHALL have outputs hit_cnt 32 and miss_cnt 32, present only under BTB_STATS_EN.

Function
REQ-010 SHALL split each PC as follows: index = pc[2+IDXW-1:2] with IDXW = log2(SETS); tag = pc[31:2+IDXW].
REQ-011 SHALL hold per entry: valid bit, tag, 32-bit target and 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-012 SHALL resolve lookups combinationally, same cycle: lookup_hit = lookup_valid AND some valid way tag-matches AND not busy.
REQ-013 SHALL drive lookup_taken = hit AND counter[1], and lookup_target = matching way's target; both SHALL be 0 on a miss.
REQ-014 SHALL, on an update hit (upd_en, tag match): increment the counter (saturating at 11) if upd_taken, else decrement it (saturating at 00); write upd_target; mark the way most-recently-used.
REQ-015 SHALL, on an update miss with upd_taken=1, allocate one way with valid=1, the new tag, upd_target, counter=10 and MRU status.
REQ-016 SHALL NOT allocate on an update miss with upd_taken=0.
REQ-017 SHALL select the allocation victim as the lowest-numbered invalid way, else the least-recently-used way.
REQ-018 SHALL implement true LRU via per-way age fields of log2(WAYS) bits: the touched way goes to 0 and younger ways increment; for WAYS=1 the age fields are empty and way 0 is always the victim.
REQ-019 SHALL NOT change LRU state on lookups.
REQ-020 SHALL, when lookup and update target the same set in one cycle, return pre-update contents to the lookup; the update takes effect at the next edge.
REQ-021 SHALL run the flush FSM as follows:
  - States IDLE and FLUSH.
  - In IDLE, flush=1 goes to FLUSH with set pointer 0.
  - FLUSH clears the valid bits of one set per cycle, all ways, incrementing the pointer.
  - FLUSH returns to IDLE after set SETS-1 is cleared, taking SETS cycles in total.
REQ-022 SHALL assert busy=1 exactly while in FLUSH, and SHALL ignore upd_en while busy.
REQ-023 SHALL restart the pointer at 0 if flush=1 is asserted during FLUSH.
REQ-024 SHALL let an update coincident with the IDLE->FLUSH transition edge be dropped.

Reset
REQ-025 SHALL, on nRST=0, asynchronously clear:
  - all valid bits, counters, targets, tags and ages;
  - the FSM to IDLE and the pointer to 0;
  - hit_cnt and miss_cnt.
REQ-026 SHALL hold reset values of all outputs at 0 (lookup_hit, lookup_taken, lookup_target, busy, counters).
REQ-027 SHALL, when reset asserts mid-flush, abort the walk immediately; after release the block is in IDLE with all entries invalid.

Configuration
REQ-028 SHALL gate the statistics feature with macro BTB_STATS_EN.
REQ-029 SHALL, when BTB_STATS_EN is defined, behave as follows:
  - hit_cnt increments on each lookup_valid with lookup_hit=1.
  - miss_cnt increments on each lookup_valid with lookup_hit=0, including lookups during busy.
  - Both saturate at 32'hFFFFFFFF and are cleared only by reset.
REQ-030 SHALL, when BTB_STATS_EN is undefined, omit the hit_cnt/miss_cnt ports and counters, with all other behaviour identical.

Verification
REQ-031 SHALL cover cold allocate: after reset, upd_en, upd_pc=0x0000_0040, upd_target=0x0000_0100, upd_taken=1; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100.
REQ-032 SHALL cover counter saturation: three not-taken updates to 0x40 -> counter 00, taken=0, hit=1; then four taken updates -> counter 11, taken=1.
REQ-033 SHALL cover LRU eviction: SETS=64, WAYS=2; allocate 0x040, 0x140 and 0x240 (same index 16), having re-updated 0x040 before 0x240 -> 0x140 misses, 0x040 and 0x240 hit.
REQ-034 SHALL cover flush: flush pulse -> busy=1 for exactly 64 cycles; a taken update during busy is ignored; afterwards every prior entry misses.
REQ-035 SHALL cover same-set collision: lookup 0x80 and taken update 0x80 in the same cycle on an empty BTB -> that cycle hit=0, next cycle hit=1.
REQ-036 SHALL cover BTB_STATS_EN: 10 lookups, 3 hits -> hit_cnt=3, miss_cnt=7; nRST pulse -> both 0.
